// File: rtl/usb_rx.sv
// Full-speed USB receive front end: pin synchronizer, 4x oversampled bit recovery,
// SYNC detect, NRZI decode, bit unstuffing, byte assembly and bus-reset detection.
`timescale 1ns/1ps
module usb_rx #(
  parameter int RESET_CYCLES = 120,
  parameter int MAX_BYTES    = 1027
) (
  input  logic       clock48,
  input  logic       reset,
  input  logic       usb_dp,
  input  logic       usb_dn,
  input  logic       rx_enable,
  output logic       rx_active,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_packet_end,
  output logic       rx_error,
  output logic       bus_reset
);

  localparam int RW = $clog2(RESET_CYCLES + 1);
  localparam int BW = $clog2(MAX_BYTES + 1);
  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_K   = 2'b01;
  localparam logic [1:0] LS_J   = 2'b10;

  typedef enum logic [1:0] {IDLE, SYNC, DATA, WAIT_IDLE} state_t;

  state_t        state, state_n;
  logic          dp_meta, dp_sync, dn_meta, dn_sync;
  logic [1:0]    line, line_q, prev_line;
  logic [1:0]    phase;
  logic          sample, nrzi_bit;
  logic [RW-1:0] se0_cnt;
  logic [2:0]    zeros, zeros_n, ones, ones_n, bit_cnt, bit_cnt_n;
  logic [7:0]    shift, shift_n, byte_next, data_n;
  logic [BW-1:0] byte_cnt, byte_cnt_n;
  logic          active_n, valid_n, end_n, error_n;

  // SE1 is folded into SE0 so the FSM only ever sees J, K or SE0.
  assign line      = (dp_sync == dn_sync) ? LS_SE0 : {dp_sync, dn_sync};
  assign sample    = (phase == 2'd2);
  assign nrzi_bit  = (line_q == prev_line);
  assign byte_next = {nrzi_bit, shift[7:1]};

  always_ff @(posedge clock48) begin
    if (reset) begin
      dp_meta   <= 1'b1;
      dp_sync   <= 1'b1;
      dn_meta   <= 1'b0;
      dn_sync   <= 1'b0;
      line_q    <= LS_J;
      prev_line <= LS_J;
      phase     <= 2'd0;
      se0_cnt   <= '0;
      bus_reset <= 1'b0;
    end else begin
      dp_meta <= usb_dp;
      dp_sync <= dp_meta;
      dn_meta <= usb_dn;
      dn_sync <= dn_meta;
      line_q  <= line;
      // Any line transition re-centres the sample point two clocks later.
      phase   <= (line != line_q) ? 2'd0 : phase + 2'd1;
      if (sample)
        prev_line <= line_q;
      if (line == LS_SE0) begin
        if (se0_cnt != RW'(RESET_CYCLES))
          se0_cnt <= se0_cnt + 1'b1;
        bus_reset <= (se0_cnt >= RW'(RESET_CYCLES - 1));
      end else begin
        se0_cnt   <= '0;
        bus_reset <= 1'b0;
      end
    end
  end

  always_comb begin
    state_n    = state;
    zeros_n    = zeros;
    ones_n     = ones;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    byte_cnt_n = byte_cnt;
    data_n     = rx_data;
    active_n   = rx_active;
    valid_n    = 1'b0;
    end_n      = 1'b0;
    error_n    = 1'b0;
    if (!rx_enable) begin
      state_n  = IDLE;
      active_n = 1'b0;
    end else if (sample) begin
      case (state)
        IDLE: begin
          if (line_q == LS_K) begin
            state_n = SYNC;
            zeros_n = 3'd1;
          end
        end
        SYNC: begin
          if (line_q == LS_SE0) begin
            state_n = IDLE;
          end else if (!nrzi_bit) begin
            if (zeros != 3'd7)
              zeros_n = zeros + 3'd1;
          end else if (zeros >= 3'd3) begin
            state_n    = DATA;
            active_n   = 1'b1;
            ones_n     = 3'd1;
            bit_cnt_n  = 3'd0;
            byte_cnt_n = '0;
          end else begin
            state_n = IDLE;
          end
        end
        DATA: begin
          if (line_q == LS_SE0) begin
            state_n  = WAIT_IDLE;
            active_n = 1'b0;
            end_n    = 1'b1;
            error_n  = (bit_cnt != 3'd0) || (byte_cnt == '0);
          end else if (ones == 3'd6) begin
            // Stuff bit: must be a transition (decoded 0), never data.
            if (nrzi_bit) begin
              state_n  = WAIT_IDLE;
              active_n = 1'b0;
              end_n    = 1'b1;
              error_n  = 1'b1;
            end else begin
              ones_n = 3'd0;
            end
          end else begin
            shift_n   = byte_next;
            bit_cnt_n = bit_cnt + 3'd1;
            ones_n    = nrzi_bit ? ones + 3'd1 : 3'd0;
            if (bit_cnt == 3'd7) begin
              if (byte_cnt == BW'(MAX_BYTES)) begin
                state_n  = WAIT_IDLE;
                active_n = 1'b0;
                end_n    = 1'b1;
                error_n  = 1'b1;
              end else begin
                data_n     = byte_next;
                valid_n    = 1'b1;
                byte_cnt_n = byte_cnt + 1'b1;
              end
            end
          end
        end
        WAIT_IDLE: begin
          if (line_q == LS_J)
            state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock48) begin
    shift <= shift_n;
    if (reset) begin
      state         <= IDLE;
      zeros         <= 3'd0;
      ones          <= 3'd0;
      bit_cnt       <= 3'd0;
      byte_cnt      <= '0;
      rx_data       <= 8'd0;
      rx_active     <= 1'b0;
      rx_valid      <= 1'b0;
      rx_packet_end <= 1'b0;
      rx_error      <= 1'b0;
    end else begin
      state         <= state_n;
      zeros         <= zeros_n;
      ones          <= ones_n;
      bit_cnt       <= bit_cnt_n;
      byte_cnt      <= byte_cnt_n;
      rx_data       <= data_n;
      rx_active     <= active_n;
      rx_valid      <= valid_n;
      rx_packet_end <= end_n;
      rx_error      <= error_n;
    end
  end

endmodule
